// File: rtl/stage_ex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : cpu_defs                                               |
// | Description : Shared definitions for the EX stage: word widths, ALU  |
// |               op codes, exception codes, the mul/div FSM state       |
// |               encoding and a small op-classification helper.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cpu_defs;

  localparam int WORD        = 32;
  localparam int WORD_ADDR_W = 30;

  // ALU operation codes carried on id_alu_op
  localparam logic [3:0] ALU_OP_THRU = 4'd0;
  localparam logic [3:0] ALU_OP_AND  = 4'd1;
  localparam logic [3:0] ALU_OP_OR   = 4'd2;
  localparam logic [3:0] ALU_OP_XOR  = 4'd3;
  localparam logic [3:0] ALU_OP_ADDS = 4'd4;
  localparam logic [3:0] ALU_OP_ADDU = 4'd5;
  localparam logic [3:0] ALU_OP_SUBS = 4'd6;
  localparam logic [3:0] ALU_OP_SUBU = 4'd7;
  localparam logic [3:0] ALU_OP_SHRL = 4'd8;
  localparam logic [3:0] ALU_OP_SHLL = 4'd9;
  localparam logic [3:0] ALU_OP_MULU = 4'd10;
  localparam logic [3:0] ALU_OP_DIVU = 4'd11;
  localparam logic [3:0] ALU_OP_REMU = 4'd12;

  // Exception codes
  localparam logic [2:0] EXP_NONE     = 3'd0;
  localparam logic [2:0] EXP_OVERFLOW = 3'd3;

  // Iterative mul/div controller states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_OP_MULU) || (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage_ex_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ex_muldiv                                              |
// | Description : 32-iteration unsigned multiplier (shift-add) and       |
// |               restoring divider shared by MULU/DIVU/REMU.            |
// | Ports       : clk, reset (sync, active-low)                          |
// |               start  - launch request (ignored unless idle)          |
// |               stall  - holds the finished result in DONE             |
// |               flush  - abandons any operation, back to idle          |
// |               op,a,b - operation and operands                        |
// |               busy   - operation in progress (incl. launch cycle)    |
// |               done   - result valid on result                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ex_muldiv
  import cpu_defs::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            flush,
  input  logic [3:0]      op,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] result
);

  md_state_t       state, state_next;
  logic [4:0]      count;
  logic [3:0]      op_q;
  // MULU: acc = product, opa = multiplicand (shifts left), opb = multiplier (shifts right)
  // DIVU/REMU: acc = partial remainder, opa = divisor, opb = dividend in / quotient out
  logic [WORD-1:0] acc, opa, opb;
  logic [WORD:0]   shifted;
  logic            fits;
  logic            launch;

  assign launch  = (state == MD_IDLE) && start && !flush;
  assign shifted = {acc, opb[WORD-1]};
  assign fits    = shifted >= {1'b0, opa};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      MD_IDLE: begin
        if (launch) begin
          state_next = MD_RUN;
          busy       = 1'b1;
        end
      end
      MD_RUN: begin
        busy = 1'b1;
        if (flush) begin
          state_next = MD_IDLE;
        end else if (count == 5'd31) begin
          state_next = MD_DONE;
        end
      end
      MD_DONE: begin
        done = 1'b1;
        if (flush || !stall) begin
          state_next = MD_IDLE;
        end
      end
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      op_q  <= '0;
      acc   <= '0;
      opa   <= '0;
      opb   <= '0;
    end else if (launch) begin
      count <= '0;
      op_q  <= op;
      acc   <= '0;
      if (op == ALU_OP_MULU) begin
        opa <= a;
        opb <= b;
      end else begin
        opa <= b;
        opb <= a;
      end
    end else if ((state == MD_RUN) && !flush) begin
      count <= count + 5'd1;
      if (op_q == ALU_OP_MULU) begin
        if (opb[0]) begin
          acc <= acc + opa;
        end
        opa <= opa << 1;
        opb <= opb >> 1;
      end else begin
        // Divide-by-zero needs no special case: every trial subtract of 0
        // succeeds, giving an all-ones quotient and remainder = dividend.
        acc <= fits ? (shifted[WORD-1:0] - opa) : shifted[WORD-1:0];
        opb <= {opb[WORD-2:0], fits};
      end
    end
  end

  always_comb begin
    result = acc;
    if (op_q == ALU_OP_DIVU) begin
      result = opb;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stage_ex.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : stage_ex                                               |
// | Description : Execute stage. Single-cycle ALU for ops 0-9, iterative |
// |               mul/div for ops 10-12, and the EX/MEM pipeline reg.    |
// | Ports       : clk, reset (sync, active-low), stall, flush            |
// |               busy     - mul/div in progress (fed back into stall)   |
// |               fwd_data - current-cycle result for forwarding to ID   |
// |               id_*     - ID/EX inputs; ex_* - registered EX/MEM outs |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module stage_ex
  import cpu_defs::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   busy,
  output logic [WORD-1:0]        fwd_data,
  input  logic [WORD_ADDR_W-1:0] id_pc,
  input  logic                   id_en,
  input  logic [3:0]             id_alu_op,
  input  logic [WORD-1:0]        id_alu_in_0,
  input  logic [WORD-1:0]        id_alu_in_1,
  input  logic                   id_br_flag,
  input  logic [1:0]             id_mem_op,
  input  logic [WORD-1:0]        id_mem_wr_data,
  input  logic [1:0]             id_ctrl_op,
  input  logic [5:0]             id_dst_addr,
  input  logic                   id_gpr_we_,
  input  logic [2:0]             id_exp_code,
  output logic [WORD_ADDR_W-1:0] ex_pc,
  output logic                   ex_en,
  output logic                   ex_br_flag,
  output logic [1:0]             ex_mem_op,
  output logic [WORD-1:0]        ex_mem_wr_data,
  output logic [1:0]             ex_ctrl_op,
  output logic [5:0]             ex_dst_addr,
  output logic                   ex_gpr_we_,
  output logic [2:0]             ex_exp_code,
  output logic [WORD-1:0]        ex_out
);

  logic            start;
  logic            md_busy;
  logic            md_done;
  logic [WORD-1:0] md_result;
  logic [WORD-1:0] alu_out;
  logic [WORD-1:0] sum;
  logic [WORD-1:0] diff;
  logic            ovf;

  // Gated by reset so busy cannot rise during a reset cycle.
  assign start = reset && id_en && is_muldiv(id_alu_op);

  ex_muldiv u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .stall  (stall),
    .flush  (flush),
    .op     (id_alu_op),
    .a      (id_alu_in_0),
    .b      (id_alu_in_1),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  assign sum  = id_alu_in_0 + id_alu_in_1;
  assign diff = id_alu_in_0 - id_alu_in_1;

  always_comb begin
    alu_out = '0;
    ovf     = 1'b0;
    case (id_alu_op)
      ALU_OP_THRU: alu_out = id_alu_in_0;
      ALU_OP_AND:  alu_out = id_alu_in_0 & id_alu_in_1;
      ALU_OP_OR:   alu_out = id_alu_in_0 | id_alu_in_1;
      ALU_OP_XOR:  alu_out = id_alu_in_0 ^ id_alu_in_1;
      ALU_OP_ADDS: begin
        alu_out = sum;
        ovf     = (id_alu_in_0[WORD-1] == id_alu_in_1[WORD-1]) &&
                  (sum[WORD-1] != id_alu_in_0[WORD-1]);
      end
      ALU_OP_ADDU: alu_out = sum;
      ALU_OP_SUBS: begin
        // Subtraction adds the negated subtrahend, so the operand signs
        // "agree" when the raw signs differ.
        alu_out = diff;
        ovf     = (id_alu_in_0[WORD-1] != id_alu_in_1[WORD-1]) &&
                  (diff[WORD-1] != id_alu_in_0[WORD-1]);
      end
      ALU_OP_SUBU: alu_out = diff;
      ALU_OP_SHRL: alu_out = id_alu_in_0 >> id_alu_in_1[4:0];
      ALU_OP_SHLL: alu_out = id_alu_in_0 << id_alu_in_1[4:0];
      default:     alu_out = '0;
    endcase
  end

  assign busy     = md_busy;
  assign fwd_data = md_done ? md_result : alu_out;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_pc          <= '0;
      ex_en          <= 1'b0;
      ex_br_flag     <= 1'b0;
      ex_mem_op      <= '0;
      ex_mem_wr_data <= '0;
      ex_ctrl_op     <= '0;
      ex_dst_addr    <= '0;
      ex_gpr_we_     <= 1'b1;
      ex_exp_code    <= EXP_NONE;
      ex_out         <= '0;
    end else if (!stall && !md_busy) begin
      if (flush) begin
        ex_pc          <= '0;
        ex_en          <= 1'b0;
        ex_br_flag     <= 1'b0;
        ex_mem_op      <= '0;
        ex_mem_wr_data <= '0;
        ex_ctrl_op     <= '0;
        ex_dst_addr    <= '0;
        ex_gpr_we_     <= 1'b1;
        ex_exp_code    <= EXP_NONE;
        ex_out         <= '0;
      end else begin
        ex_pc          <= id_pc;
        ex_en          <= id_en;
        ex_br_flag     <= id_br_flag;
        ex_mem_op      <= id_mem_op;
        ex_mem_wr_data <= id_mem_wr_data;
        ex_ctrl_op     <= id_ctrl_op;
        ex_dst_addr    <= id_dst_addr;
        ex_gpr_we_     <= (ovf && id_en) ? 1'b1 : id_gpr_we_;
        ex_exp_code    <= (ovf && id_en) ? EXP_OVERFLOW : id_exp_code;
        ex_out         <= fwd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_ex.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_stage_ex                                            |
// | Description : Self-checking bench for stage_ex: directed vector      |
// |               table, stall/flush/reset sequences and random ops      |
// |               checked against an arithmetic reference model.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_stage_ex;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_ext;
  logic        stall;
  logic        flush;
  logic        busy;
  logic [31:0] fwd_data;
  logic [29:0] id_pc;
  logic        id_en;
  logic [3:0]  id_alu_op;
  logic [31:0] id_alu_in_0, id_alu_in_1;
  logic        id_br_flag;
  logic [1:0]  id_mem_op;
  logic [31:0] id_mem_wr_data;
  logic [1:0]  id_ctrl_op;
  logic [5:0]  id_dst_addr;
  logic        id_gpr_we_;
  logic [2:0]  id_exp_code;
  logic [29:0] ex_pc;
  logic        ex_en, ex_br_flag, ex_gpr_we_;
  logic [1:0]  ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [5:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // The pipeline controller ORs busy into stall.
  assign stall = stall_ext | busy;

  stage_ex dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .busy(busy), .fwd_data(fwd_data),
    .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
    .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
    .id_br_flag(id_br_flag), .id_mem_op(id_mem_op),
    .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op),
    .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
    .id_exp_code(id_exp_code),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag),
    .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data),
    .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_pc = '0; id_en = 1'b0; id_alu_op = '0; id_alu_in_0 = '0; id_alu_in_1 = '0;
    id_br_flag = 1'b0; id_mem_op = '0; id_mem_wr_data = '0; id_ctrl_op = '0;
    id_dst_addr = '0; id_gpr_we_ = 1'b1; id_exp_code = '0;
    flush = 1'b0; stall_ext = 1'b0;
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic ovf);
    longint s;
    logic [63:0] p;
    r = '0; ovf = 1'b0; s = 0;
    case (op)
      4'd0:  r = a;
      4'd1:  r = a & b;
      4'd2:  r = a | b;
      4'd3:  r = a ^ b;
      4'd4:  begin s = longint'($signed(a)) + longint'($signed(b)); r = s[31:0];
                   ovf = (s != longint'($signed(r))); end
      4'd5:  r = a + b;
      4'd6:  begin s = longint'($signed(a)) - longint'($signed(b)); r = s[31:0];
                   ovf = (s != longint'($signed(r))); end
      4'd7:  r = a - b;
      4'd8:  r = a >> b[4:0];
      4'd9:  r = a << b[4:0];
      4'd10: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      4'd11: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
  endfunction

  // Issue one instruction with random side fields, wait for it to land in
  // ex_reg and check every registered field.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic en, input logic [31:0] exp_r, input logic exp_ovf);
    logic [29:0] pc, prev_pc;
    logic        br, we, is_md;
    logic [1:0]  mop, cop;
    logic [31:0] wd;
    logic [5:0]  dst;
    logic [2:0]  ec;
    int          bc;
    pc = 30'($urandom); br = 1'($urandom); mop = 2'($urandom); cop = 2'($urandom);
    wd = $urandom; dst = 6'($urandom); we = 1'($urandom); ec = 3'($urandom);
    prev_pc = ex_pc;
    id_pc = pc; id_en = en; id_alu_op = op; id_alu_in_0 = a; id_alu_in_1 = b;
    id_br_flag = br; id_mem_op = mop; id_mem_wr_data = wd; id_ctrl_op = cop;
    id_dst_addr = dst; id_gpr_we_ = we; id_exp_code = ec;
    flush = 1'b0; stall_ext = 1'b0;
    #1;
    is_md = en && (op >= 4'd10) && (op <= 4'd12);
    bc = 0;
    if (is_md) begin
      while (busy && bc < 100) begin
        tick();
        bc++;
      end
      chk("md_busy_cycles", 32'(bc), 32'd33);
      chk("md_hold_pc", 32'(ex_pc), 32'(prev_pc));
    end else begin
      chk("alu_busy", 32'(busy), 32'd0);
    end
    chk("fwd_data", fwd_data, exp_r);
    tick();
    chk("ex_out", ex_out, exp_r);
    chk("ex_en", 32'(ex_en), 32'(en));
    chk("ex_pc", 32'(ex_pc), 32'(pc));
    chk("ex_side", {ex_br_flag, ex_mem_op, ex_ctrl_op, ex_dst_addr, 21'd0},
                   {br, mop, cop, dst, 21'd0});
    chk("ex_mem_wr_data", ex_mem_wr_data, wd);
    chk("ex_exp_code", 32'(ex_exp_code), (exp_ovf && en) ? 32'd3 : 32'(ec));
    chk("ex_gpr_we_", 32'(ex_gpr_we_), (exp_ovf && en) ? 32'd1 : 32'(we));
    set_idle();
  endtask

  vec_t        vecs[17];
  logic [31:0] r, a, b, held;
  logic [3:0]  op;
  logic        ovf, en;
  int          stale;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'd5,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
    vecs[1]  = '{4'd4,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1};
    vecs[2]  = '{4'd4,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
    vecs[3]  = '{4'd6,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1};
    vecs[4]  = '{4'd7,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0};
    vecs[5]  = '{4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    vecs[6]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0};
    vecs[7]  = '{4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
    vecs[8]  = '{4'd8,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0};
    vecs[9]  = '{4'd9,  32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0};
    vecs[10] = '{4'd0,  32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0};
    vecs[11] = '{4'd14, 32'h1234_5678, 32'hDEAD_BEEF, 32'd0,         1'b0};
    vecs[12] = '{4'd10, 32'd12345,     32'd6789,      32'd83810205,  1'b0};
    vecs[13] = '{4'd11, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[14] = '{4'd12, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[15] = '{4'd11, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0};
    vecs[16] = '{4'd12, 32'd5,         32'd0,         32'd5,         1'b0};

    set_idle();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_ex_out", ex_out, 32'd0);
    chk("rst_ex_en", 32'(ex_en), 32'd0);
    chk("rst_ex_gpr_we_", 32'(ex_gpr_we_), 32'd1);
    chk("rst_ex_pc", 32'(ex_pc), 32'd0);
    chk("rst_ex_exp_code", 32'(ex_exp_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].ovf);
    end

    // External stall holds ex_reg.
    held = ex_out;
    id_en = 1'b1; id_alu_op = 4'd5; id_alu_in_0 = 32'd40; id_alu_in_1 = 32'd2;
    stall_ext = 1'b1;
    tick();
    chk("stall_hold_1", ex_out, held);
    tick();
    chk("stall_hold_2", ex_out, held);
    stall_ext = 1'b0;
    tick();
    chk("stall_release", ex_out, 32'd42);
    set_idle();

    // Flush at RUN count 10 of a DIVU; keep flush for a second cycle so it
    // also blocks a restart and loads the bubble.
    id_en = 1'b1; id_alu_op = 4'd11; id_alu_in_0 = 32'd1000; id_alu_in_1 = 32'd3;
    id_pc = 30'h155; id_gpr_we_ = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    chk("flush_pre_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    chk("flush_busy_next", 32'(busy), 32'd0);
    tick();
    chk("flush_ex_en", 32'(ex_en), 32'd0);
    chk("flush_ex_gpr_we_", 32'(ex_gpr_we_), 32'd1);
    chk("flush_ex_out", ex_out, 32'd0);
    chk("flush_ex_pc", 32'(ex_pc), 32'd0);
    set_idle();
    run_op(4'd5, 32'd2, 32'd3, 1'b1, 32'd5, 1'b0);

    // One-cycle reset in the middle of a MULU.
    run_op(4'd0, 32'hA5A5_A5A5, 32'd0, 1'b1, 32'hA5A5_A5A5, 1'b0);
    id_en = 1'b1; id_alu_op = 4'd10; id_alu_in_0 = 32'd12345; id_alu_in_1 = 32'd6789;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_idle();
    chk("mrst_ex_out", ex_out, 32'd0);
    chk("mrst_ex_en", 32'(ex_en), 32'd0);
    chk("mrst_ex_gpr_we_", 32'(ex_gpr_we_), 32'd1);
    chk("mrst_busy", 32'(busy), 32'd0);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ex_out !== 32'd0 || busy !== 1'b0) stale++;
    end
    chk("mrst_no_stale", 32'(stale), 32'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      en = (op >= 4'd10 && op <= 4'd12) ? 1'b1 : 1'($urandom);
      ref_model(op, a, b, r, ovf);
      run_op(op, a, b, en, r, ovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
